// File: rtl/level_state_ctrl.sv
// level_state_ctrl: level flow FSM (idle/restart/play/dying/win/game over),
// lives counter and optional level timer (enable with LEVEL_TIMER_EN).
//
// Ports:
//   Clk, Reset         - clock, synchronous active-high reset
//   frame_tick         - one-cycle pulse per video frame
//   player1/2_dead     - latched death flags from hazard controller
//   player1/2_at_door  - players inside their exit doors
//   start_key          - start/continue key (level)
//   state              - IDLE=0 RESTART=1 PLAYING=2 DYING=3 WIN=4 GAME_OVER=5
//   level_reset        - clears hazards/players (high in IDLE and RESTART)
//   freeze             - halts player motion outside PLAYING
//   lives              - remaining lives
//   elapsed_sec        - level time in seconds (0 without LEVEL_TIMER_EN)

module level_state_ctrl #(
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 90,
    parameter int DOOR_FRAMES  = 30,
    parameter int RESET_CYCLES = 4,
    parameter int FPS          = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       player1_dead,
    input  logic       player2_dead,
    input  logic       player1_at_door,
    input  logic       player2_at_door,
    input  logic       start_key,
    output logic [2:0] state,
    output logic       level_reset,
    output logic       freeze,
    output logic [1:0] lives,
    output logic [9:0] elapsed_sec
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESTART   = 3'd1,
        S_PLAYING   = 3'd2,
        S_DYING     = 3'd3,
        S_WIN       = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] RST_LAST   = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] DOOR_LAST  = 8'(DOOR_FRAMES - 1);
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);

    // Elaboration-time range guard on the configuration.
    if (LIVES < 1 || LIVES > 3 || DEATH_FRAMES < 1 || DEATH_FRAMES > 255 ||
        DOOR_FRAMES < 1 || DOOR_FRAMES > 255 || RESET_CYCLES < 1 ||
        RESET_CYCLES > 255 || FPS < 1 || FPS > 255) begin : g_bad_param
        $error("level_state_ctrl: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] cyc_cnt_q, cyc_cnt_d;
    logic [7:0] door_cnt_q, door_cnt_d;
    logic [7:0] frm_cnt_q, frm_cnt_d;
    logic       key_q;
    logic       start_edge;
    logic       any_dead;
    logic       both_door;

    assign start_edge = start_key & ~key_q;
    assign any_dead   = player1_dead | player2_dead;
    assign both_door  = player1_at_door & player2_at_door;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        cyc_cnt_d  = cyc_cnt_q;
        door_cnt_d = door_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    lives_d = LIVES_INIT;
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                if (cyc_cnt_q == RST_LAST) begin
                    state_d = S_PLAYING;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 8'd1;
                end
            end
            S_PLAYING: begin
                // Death wins over a simultaneous final door tick.
                if (any_dead) begin
                    state_d = S_DYING;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end else if (frame_tick) begin
                    if (!both_door) begin
                        door_cnt_d = 8'd0;
                    end else if (door_cnt_q == DOOR_LAST) begin
                        state_d = S_WIN;
                    end else begin
                        door_cnt_d = door_cnt_q + 8'd1;
                    end
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (frm_cnt_q == DEATH_LAST) begin
                        state_d = (lives_q == 2'd0) ? S_GAME_OVER : S_RESTART;
                    end else begin
                        frm_cnt_d = frm_cnt_q + 8'd1;
                    end
                end
            end
            S_WIN: begin
                if (start_edge) begin
                    state_d = S_RESTART;
                end
            end
            S_GAME_OVER: begin
                if (start_edge) begin
                    lives_d = LIVES_INIT;
                    state_d = S_RESTART;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Every state entry starts its counters from zero.
        if (state_d != state_q) begin
            cyc_cnt_d  = 8'd0;
            door_cnt_d = 8'd0;
            frm_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            lives_q    <= LIVES_INIT;
            cyc_cnt_q  <= 8'd0;
            door_cnt_q <= 8'd0;
            frm_cnt_q  <= 8'd0;
            key_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            cyc_cnt_q  <= cyc_cnt_d;
            door_cnt_q <= door_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            key_q      <= start_key;
        end
    end

`ifdef LEVEL_TIMER_EN
    localparam logic [7:0] FPS_LAST = 8'(FPS - 1);

    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [9:0] sec_q, sec_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        sec_d       = sec_q;
        if (state_q == S_RESTART) begin
            frame_cnt_d = 8'd0;
            sec_d       = 10'd0;
        end else if (state_q == S_PLAYING && frame_tick) begin
            if (frame_cnt_q == FPS_LAST) begin
                frame_cnt_d = 8'd0;
                if (sec_q != 10'd999) begin
                    sec_d = sec_q + 10'd1;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_q <= 8'd0;
            sec_q       <= 10'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            sec_q       <= sec_d;
        end
    end

    assign elapsed_sec = sec_q;
`else
    assign elapsed_sec = 10'd0;
`endif

    assign state       = state_q;
    assign level_reset = (state_q == S_IDLE) || (state_q == S_RESTART);
    assign freeze      = (state_q != S_PLAYING);
    assign lives       = lives_q;

endmodule
